// File: rtl/imem_loader.sv
// imem_loader: shares the instruction RAM port between CPU fetch and a serial program loader.
// Loads big-endian words from word 0, verifies an 8-bit checksum, then restarts the CPU at 0.
module imem_loader #(
    parameter int ROM_BIT = 7
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               load_req,
    input  logic               rx_valid,
    input  logic [7:0]         rx_data,
    output logic               rx_ready,
    input  logic [31:0]        cpu_addr,
    output logic [31:0]        instruction,
    output logic               cpu_hold,
    output logic               cpu_restart,
    output logic [ROM_BIT-1:0] mem_addr,
    output logic [31:0]        mem_wdata,
    output logic               mem_we,
    input  logic [31:0]        mem_rdata,
    output logic               busy,
    output logic               done,
    output logic               err
);
    localparam int CW = ROM_BIT + 1;
    localparam int ROM_SIZE = 1 << ROM_BIT;

    typedef enum logic [2:0] {RUN, HDR, DATA, WRITE, CHK, ERR} state_t;

    state_t        state, state_nx;
    logic [CW-1:0] wcnt, n, wcnt_inc;
    logic [1:0]    bidx;
    logic [7:0]    csum;
    logic [31:0]   word;
    logic          done_q, acc, hdr_bad, start, unused;

    assign acc      = rx_valid && rx_ready;
    assign hdr_bad  = rx_data == 8'd0 || 32'(rx_data) > ROM_SIZE;
    assign start    = load_req && (state == RUN || state == ERR);
    assign wcnt_inc = wcnt + CW'(1);
    assign unused   = ^{cpu_addr[31:ROM_BIT+2], cpu_addr[1:0]};

    assign busy        = state == HDR || state == DATA || state == WRITE || state == CHK;
    assign err         = state == ERR;
    assign done        = done_q;
    assign cpu_restart = done_q;
    assign mem_wdata   = word;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= RUN;
        else       state <= state_nx;
    end

    always_comb begin
        state_nx    = state;
        rx_ready    = 1'b0;
        mem_we      = 1'b0;
        cpu_hold    = state != RUN;
        instruction = state == RUN ? mem_rdata : 32'h0;
        mem_addr    = state == RUN ? cpu_addr[ROM_BIT+1:2] : state == ERR ? '0 : wcnt[ROM_BIT-1:0];
        case (state)
            RUN:   if (load_req) state_nx = HDR;
            HDR: begin
                rx_ready = 1'b1;
                if (rx_valid) state_nx = hdr_bad ? ERR : DATA;
            end
            DATA: begin
                rx_ready = 1'b1;
                if (rx_valid && bidx == 2'd3) state_nx = WRITE;
            end
            WRITE: begin
                mem_we   = 1'b1;
                state_nx = wcnt_inc == n ? CHK : DATA;
            end
            CHK: begin
                rx_ready = 1'b1;
                if (rx_valid) state_nx = rx_data == csum ? RUN : ERR;
            end
            ERR:   if (load_req) state_nx = HDR;
            default: state_nx = RUN;
        endcase
    end

    // byte index wraps to 0 on the 4th byte, so WRITE returns to DATA ready for the next word
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wcnt   <= '0;
            n      <= '0;
            bidx   <= '0;
            csum   <= '0;
            word   <= '0;
            done_q <= 1'b0;
        end else begin
            done_q <= state == CHK && acc && rx_data == csum;
            if (start) begin
                wcnt <= '0;
                bidx <= '0;
                csum <= '0;
            end
            if (state == HDR && acc && !hdr_bad) n <= CW'(rx_data);
            if (state == DATA && acc) begin
                word <= {word[23:0], rx_data};
                csum <= csum + rx_data;
                bidx <= bidx + 2'd1;
            end
            if (state == WRITE) wcnt <= wcnt_inc;
        end
    end
endmodule

// File: doc/imem_loader.md
# imem_loader

Instruction-memory load controller and port arbiter for the single-cycle MIPS core. It owns the single port of the writable instruction RAM and shares it between CPU instruction fetch (normal run) and a serial program loader fed by the UART receive byte stream. During a load it holds the CPU and feeds it NOPs. It assembles bytes into big-endian words, writes them from word 0 upward, verifies a checksum, then releases the CPU with a restart pulse so execution begins at address 0.

## Interface
- ROM_BIT, 7, word-address width; RAM depth ROM_SIZE = 2^ROM_BIT words
- clk  in  1  system clock, all state on rising edge
- reset  in  1  asynchronous, active-high
- load_req  in  1  level; sampled in RUN or ERR to start a load
- rx_valid  in  1  receive byte available
- rx_data  in  8  receive byte
- rx_ready  out  1  byte accepted on a cycle with rx_valid && rx_ready
- cpu_addr  in  32  CPU PC, byte address
- instruction  out  32  instruction to CPU
- cpu_hold  out  1  CPU must not advance PC or write state
- cpu_restart  out  1  one-cycle pulse; CPU PC is 0 on the next cycle
- mem_addr  out  ROM_BIT  RAM word address
- mem_wdata  out  32  RAM write data
- mem_we  out  1  RAM write enable, written on the clk edge ending the cycle
- mem_rdata  in  32  RAM combinational read data
- busy  out  1  load in progress (HDR, DATA, WRITE, CHK)
- done  out  1  one-cycle pulse when a load is verified
- err  out  1  sticky load failure

## Operation
- States: RUN, HDR, DATA, WRITE, CHK, ERR.
- RUN:
  - mem_addr = cpu_addr[ROM_BIT+1:2]; instruction = mem_rdata; cpu_hold=0; rx_ready=0.
  - load_req=1 goes to HDR; clear word counter, byte index and checksum.
- In every non-RUN state: instruction = 32'h00000000 (NOP), cpu_hold=1.
  - mem_addr = word counter, except in ERR, where it is 0.
- HDR: rx_ready=1.
  - Accepted byte N is the word count.
  - N==0 or N>ROM_SIZE goes to ERR.
  - Otherwise store N and go to DATA.
- DATA: rx_ready=1.
  - Each accepted byte shifts into a 32-bit assembly register, first byte landing in bits 31:24.
  - The checksum accumulates byte + checksum mod 256 (8-bit wrap).
  - On the 4th byte (index 3), go to WRITE.
- WRITE: rx_ready=0; mem_we=1; mem_wdata = assembled word; mem_addr = word counter.
  - The word counter increments.
  - If the counter after increment == N, go to CHK; else return to DATA with byte index 0.
- CHK: rx_ready=1.
  - If the accepted byte == checksum, go to RUN and assert done=1 and cpu_restart=1 for that first RUN cycle.
  - If it differs, go to ERR.
- ERR: err=1, cpu_hold=1, rx_ready=0.
  - load_req=1 clears err and goes to HDR with counters cleared.
- load_req is ignored while busy. rx_valid is ignored when rx_ready=0; the byte is not consumed.
- Words above N-1 keep their previous contents.
- Arithmetic widths:
  - Word counter is ROM_BIT+1 bits, so a count of ROM_SIZE is representable; no wrap.
  - Byte index is 2 bits.
  - N is stored in ROM_BIT+1 bits after the range check.

## Timing
- Reset (async) forces RUN and clears all registers. Outputs in reset: rx_ready=0, cpu_hold=0, cpu_restart=0, mem_we=0, mem_wdata=0, busy=0, done=0, err=0.
  - Reset mid-load abandons the load; the RAM is left partially written.
- RUN fetch path is purely combinational: zero added latency.
- load_req sampled high in RUN: cpu_hold=1 from the next cycle.
- 4th data byte accepted at cycle t: mem_we=1 in cycle t+1. The next byte can be accepted at t+2.
- Byte throughput: at most 4 bytes per 5 cycles in DATA.
- Total load: 1 + 5N + 1 cycles minimum, plus the restart cycle.
- done and cpu_restart are high together for exactly one cycle; cpu_hold is 0 in that same cycle.
- err is asserted the cycle after the offending byte is accepted and holds until load_req.

## Test plan
- Reset, then RUN with cpu_addr=0x0000000C:
  - mem_addr=3 and instruction tracks mem_rdata combinationally.
  - All outputs take their reset values during reset.
- Load bytes 02,20,08,00,14,01,00,00,08, then checksum 45:
  - Word 0 written 0x20080014, word 1 written 0x01000008, each with a one-cycle mem_we.
  - done=1 and cpu_restart=1 for one cycle; cpu_hold drops in that cycle; err=0.
- Same stream with checksum 46:
  - err=1, cpu_hold stays 1, no done.
  - A later load_req clears err and accepts a new header.
- Header 00, and header 81 with ROM_BIT=7: ERR next cycle, no mem_we at any point.
- rx_valid held high continuously with bytes queued:
  - rx_ready=0 during each WRITE cycle; no byte lost or duplicated.
  - Checksum over 4 bytes of FF wraps to FC.
- Assert reset in the middle of DATA (after 6 bytes):
  - Immediate RUN, cpu_hold=0, busy=0.
  - A fresh load_req plus a valid 1-word stream completes normally at word 0.
